seven_segment_scanner: RTL and testbench

Parametrised, time-multiplexed successor to the per-digit BCD-to-7-segment fan-out. It accepts a full frame of BCD digits from `fp_convertor` through a valid/ready handshake and double-buffers it. It then drives a single shared segment bus plus a one-hot digit-enable vector, scanning digits with a programmable on-time and an anti-ghosting blank gap. It sits between `fp_convertor` and the board pins, replacing DISPLAY_WIDTH parallel decoders.

---
 rtl/seven_segment_scanner.sv | 246 ++++++++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Brief    : Double-buffered, time-multiplexed BCD to 7-segment scanner with a
//            programmable per-digit on-time and an anti-ghosting blank gap.
//            Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int DISPLAY_WIDTH = 8,
    parameter int SHOW_CYCLES   = 1000,
    parameter int BLANK_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DISPLAY_WIDTH*4-1:0] bcd,
    input  logic                       bcd_valid,
    output logic                       bcd_ready,
    output logic [6:0]                 segments,
    output logic [DISPLAY_WIDTH-1:0]   digit_enable,
    output logic                       frame_start
);

    localparam int c_MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
    localparam int c_IDX_W      = (DISPLAY_WIDTH > 1) ? $clog2(DISPLAY_WIDTH) : 1;
    localparam int c_BUF_W      = DISPLAY_WIDTH * 4;

    localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(SHOW_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST =
        (BLANK_CYCLES > 0) ? c_CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(DISPLAY_WIDTH - 1);
    localparam logic [DISPLAY_WIDTH-1:0] c_DE_ONE = DISPLAY_WIDTH'(1);

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;
    // With no gap configured every digit period starts directly in SHOW.
    localparam logic [0:0] c_ST_FIRST = (BLANK_CYCLES > 0) ? c_ST_BLANK : c_ST_SHOW;

    generate
        if (DISPLAY_WIDTH < 1) begin : g_bad_width
            $error("DISPLAY_WIDTH must be >= 1");
        end
        if (SHOW_CYCLES < 1) begin : g_bad_show
            $error("SHOW_CYCLES must be >= 1");
        end
        if (BLANK_CYCLES < 0) begin : g_bad_blank
            $error("BLANK_CYCLES must be >= 0");
        end
    endgenerate

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [c_IDX_W-1:0]  r_index;
    logic [c_IDX_W-1:0]  w_index_next;
    logic                w_frame_wrap;

    logic [c_BUF_W-1:0]  r_shadow;
    logic [c_BUF_W-1:0]  r_active;
    logic                r_pending;
    logic                w_pending_next;
    logic                r_ready;
    logic                w_xfer;
    logic                w_swap;

    logic [c_BUF_W-1:0]  w_active_shifted;
    logic [3:0]          w_cur_digit;
    logic                w_digit_blanked;

    logic [6:0]               r_segments;
    logic [6:0]               w_segments_next;
    logic [DISPLAY_WIDTH-1:0] r_digit_enable;
    logic [DISPLAY_WIDTH-1:0] w_digit_enable_next;
    logic                     r_frame_start;
    logic                     w_frame_start_next;

    function automatic logic [6:0] decode_bcd(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h40;
            default: glyph = 7'h00;
        endcase
        return glyph;
    endfunction

    // ------------------------------------------------------------------
    // Scan FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_FIRST;
            r_cnt   <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_index <= w_index_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_index_next = r_index;
        w_frame_wrap = 1'b0;
        case (r_state)
            c_ST_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_state_next = c_ST_SHOW;
                    w_cnt_next   = '0;
                end
            end
            c_ST_SHOW: begin
                if (r_cnt == c_SHOW_LAST) begin
                    w_state_next = c_ST_FIRST;
                    w_cnt_next   = '0;
                    if (r_index == c_LAST_IDX) begin
                        w_index_next = '0;
                        w_frame_wrap = 1'b1;
                    end else begin
                        w_index_next = r_index + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = c_ST_FIRST;
                w_cnt_next   = '0;
                w_index_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame double buffer. Transfer and swap are mutually exclusive since
    // a transfer needs pending low and a swap needs it high.
    // ------------------------------------------------------------------
    assign w_xfer = bcd_valid && r_ready;
    assign w_swap = w_frame_wrap && r_pending;

    always_comb begin
        w_pending_next = r_pending;
        if (w_swap) begin
            w_pending_next = 1'b0;
        end else if (w_xfer) begin
            w_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= '1;
            r_active  <= '1;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            if (w_xfer) begin
                r_shadow <= bcd;
            end
            if (w_swap) begin
                r_active <= r_shadow;
            end
            r_pending <= w_pending_next;
            r_ready   <= !w_pending_next;
        end
    end

    assign w_active_shifted = r_active >> {r_index, 2'b00};
    assign w_cur_digit      = w_active_shifted[3:0];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DISPLAY_WIDTH-1:0] r_lz_mask;
    logic [DISPLAY_WIDTH-1:0] w_lz_mask_next;
    logic [DISPLAY_WIDTH-1:0] w_lz_shifted;
    logic                     w_zero_run;

    // Mask is built from the shadow so it lands in step with the swap.
    always_comb begin
        w_lz_mask_next = '0;
        w_zero_run     = 1'b1;
        for (int i = DISPLAY_WIDTH - 1; i >= 1; i--) begin
            w_zero_run        = w_zero_run && (r_shadow[i*4 +: 4] == 4'h0);
            w_lz_mask_next[i] = w_zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lz_mask <= '0;
        end else if (w_swap) begin
            r_lz_mask <= w_lz_mask_next;
        end
    end

    assign w_lz_shifted    = r_lz_mask >> r_index;
    assign w_digit_blanked = w_lz_shifted[0];
`else
    assign w_digit_blanked = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scan FSM: output logic, registered one cycle behind the state
    // ------------------------------------------------------------------
    always_comb begin
        w_segments_next     = 7'h00;
        w_digit_enable_next = '0;
        if (r_state == c_ST_SHOW) begin
            w_digit_enable_next = c_DE_ONE << r_index;
            w_segments_next     = w_digit_blanked ? 7'h00 : decode_bcd(w_cur_digit);
        end
        w_frame_start_next = (r_state == c_ST_FIRST) && (r_cnt == '0) && (r_index == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_segments     <= 7'h00;
            r_digit_enable <= '0;
            r_frame_start  <= 1'b0;
        end else begin
            r_segments     <= w_segments_next;
            r_digit_enable <= w_digit_enable_next;
            r_frame_start  <= w_frame_start_next;
        end
    end

    assign segments     = r_segments;
    assign digit_enable = r_digit_enable;
    assign frame_start  = r_frame_start;
    assign bcd_ready    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Brief    : Scoreboard bench for seven_segment_scanner (4 digits, 3/1 timing,
//            plus a gap-free instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

    typedef struct packed {
        logic [3:0] de;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        bcd_ready;
    logic [6:0]  segments;
    logic [3:0]  digit_enable;
    logic        frame_start;

    logic        reset0;
    logic [15:0] bcd0;
    logic        bcd_valid0;
    logic        bcd_ready0;
    logic [6:0]  segments0;
    logic [3:0]  digit_enable0;
    logic        frame_start0;

    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    seven_segment_scanner #(
        .DISPLAY_WIDTH (4),
        .SHOW_CYCLES   (3),
        .BLANK_CYCLES  (1)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .bcd          (bcd),
        .bcd_valid    (bcd_valid),
        .bcd_ready    (bcd_ready),
        .segments     (segments),
        .digit_enable (digit_enable),
        .frame_start  (frame_start)
    );

    seven_segment_scanner #(
        .DISPLAY_WIDTH (4),
        .SHOW_CYCLES   (3),
        .BLANK_CYCLES  (0)
    ) u_dut0 (
        .clk          (clk),
        .reset        (reset0),
        .bcd          (bcd0),
        .bcd_valid    (bcd_valid0),
        .bcd_ready    (bcd_ready0),
        .segments     (segments0),
        .digit_enable (digit_enable0),
        .frame_start  (frame_start0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // One 16-cycle frame of the 4-digit, 1-blank/3-show instance.
    task automatic push_frame(input logic [15:0] digs);
        logic [3:0] mask;
        exp_t       e;
        mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic run;
            run = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                run     = run && (digs[i*4 +: 4] == 4'h0);
                mask[i] = run;
            end
        end
`endif
        for (int k = 0; k < 16; k++) begin
            int d;
            int ph;
            d     = k / 4;
            ph    = k % 4;
            e.fs  = (k == 0);
            e.de  = (ph == 0) ? 4'b0000 : 4'(1 << d);
            e.seg = (ph == 0 || mask[d]) ? 7'h00 : glyph(digs[d*4 +: 4]);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int nframes);
        exp_t e;
        for (int k = 0; k < 16 * nframes; k++) begin
            e.fs  = ((k % 16) == 0);
            e.de  = ((k % 4) == 0) ? 4'b0000 : 4'(1 << ((k / 4) % 4));
            e.seg = 7'h00;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_fs(input string tag);
        int t;
        t = 0;
        while (frame_start !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (frame_start !== 1'b1) begin
            n_checks++;
            $display("FAIL %s_timeout: frame_start=%b required 1", tag, frame_start);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bcd_valid = 1'b0;
        bcd       = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (segments !== 7'h00) $display("FAIL reset_segments: got %h required 00", segments);
        else n_pass++;
        n_checks++;
        if (digit_enable !== 4'b0000) $display("FAIL reset_digit_enable: got %b required 0000", digit_enable);
        else n_pass++;
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b required 0", frame_start);
        else n_pass++;
        n_checks++;
        if (bcd_ready !== 1'b1) $display("FAIL reset_bcd_ready: got %b required 1", bcd_ready);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle();
        exp_t e;
        push_idle(2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (digit_enable !== e.de || segments !== e.seg || frame_start !== e.fs)
                $display("FAIL idle_scan: got de=%b seg=%h fs=%b required de=%b seg=%h fs=%b",
                         digit_enable, segments, frame_start, e.de, e.seg, e.fs);
            else n_pass++;
            n_checks++;
            if (bcd_ready !== 1'b1) $display("FAIL idle_ready: got %b required 1", bcd_ready);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        exp_t e;
        logic r1;
        logic r2;
        int   t;
        wait_fs("load_sync");
        repeat (5) @(negedge clk);
        n_checks++;
        if (bcd_ready !== 1'b1) $display("FAIL load_ready_before: got %b required 1", bcd_ready);
        else n_pass++;
        bcd       = 16'h1234;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        bcd       = 16'hFFFF;
        n_checks++;
        if (bcd_ready !== 1'b0) $display("FAIL load_ready_fall: got %b required 0", bcd_ready);
        else n_pass++;
        r1 = 1'bx;
        r2 = 1'bx;
        t  = 0;
        while (frame_start !== 1'b1 && t < 40) begin
            n_checks++;
            if (segments !== 7'h00) $display("FAIL load_unchanged: got seg=%h required 00", segments);
            else n_pass++;
            r2 = r1;
            r1 = bcd_ready;
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (frame_start !== 1'b1) $display("FAIL load_fs_timeout: frame_start=%b required 1", frame_start);
        else n_pass++;
        n_checks++;
        if (r2 !== 1'b0) $display("FAIL load_ready_pre_swap: got %b required 0", r2);
        else n_pass++;
        n_checks++;
        if (bcd_ready !== 1'b1) $display("FAIL load_ready_rise: got %b required 1", bcd_ready);
        else n_pass++;
        push_frame(16'h1234);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (digit_enable !== e.de || segments !== e.seg || frame_start !== e.fs)
                $display("FAIL load_frame: got de=%b seg=%h fs=%b required de=%b seg=%h fs=%b",
                         digit_enable, segments, frame_start, e.de, e.seg, e.fs);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n_wait;
        wait_fs("b2b_sync");
        repeat (2) @(negedge clk);
        bcd       = 16'h5678;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd    = 16'h90AB;
        n_wait = 0;
        while (bcd_ready !== 1'b1 && n_wait < 40) begin
            @(negedge clk);
            n_wait++;
        end
        n_checks++;
        if (n_wait < 2 || bcd_ready !== 1'b1)
            $display("FAIL b2b_holdoff: held %0d cycles ready=%b required >=2 cycles then 1", n_wait, bcd_ready);
        else n_pass++;
        @(negedge clk);
        bcd_valid = 1'b0;
        bcd       = 16'h0000;
        n_checks++;
        if (bcd_ready !== 1'b0) $display("FAIL b2b_second_accept: ready=%b required 0", bcd_ready);
        else n_pass++;
        wait_fs("b2b_frame");
        push_frame(16'h5678);
        push_frame(16'h90AB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (digit_enable !== e.de || segments !== e.seg || frame_start !== e.fs)
                $display("FAIL b2b_frame: got de=%b seg=%h fs=%b required de=%b seg=%h fs=%b",
                         digit_enable, segments, frame_start, e.de, e.seg, e.fs);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_leading_zero();
        exp_t e;
        wait_fs("lz_sync");
        repeat (5) @(negedge clk);
        n_checks++;
        if (bcd_ready !== 1'b1) $display("FAIL lz_ready: got %b required 1", bcd_ready);
        else n_pass++;
        bcd       = 16'h00A7;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        wait_fs("lz_frame");
        push_frame(16'h00A7);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (digit_enable !== e.de || segments !== e.seg || frame_start !== e.fs)
                $display("FAIL lz_frame: got de=%b seg=%h fs=%b required de=%b seg=%h fs=%b",
                         digit_enable, segments, frame_start, e.de, e.seg, e.fs);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int   t;
        wait_fs("rst_sync");
        @(negedge clk);
        bcd       = 16'h8888;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        n_checks++;
        if (bcd_ready !== 1'b0) $display("FAIL rst_pending: ready=%b required 0", bcd_ready);
        else n_pass++;
        t = 0;
        while (digit_enable !== 4'b0100 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (digit_enable !== 4'b0100) $display("FAIL rst_idx2_timeout: de=%b required 0100", digit_enable);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({segments, digit_enable, frame_start, bcd_ready} !== {7'h00, 4'b0000, 1'b0, 1'b1})
            $display("FAIL rst_mid_outputs: got seg=%h de=%b fs=%b ready=%b required 00 0000 0 1",
                     segments, digit_enable, frame_start, bcd_ready);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        push_idle(2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (digit_enable !== e.de || segments !== e.seg || frame_start !== e.fs)
                $display("FAIL rst_after_scan: got de=%b seg=%h fs=%b required de=%b seg=%h fs=%b",
                         digit_enable, segments, frame_start, e.de, e.seg, e.fs);
            else n_pass++;
            n_checks++;
            if (bcd_ready !== 1'b1) $display("FAIL rst_after_ready: got %b required 1", bcd_ready);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_blank_zero();
        exp_t e;
        reset0 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            e.fs  = ((k % 12) == 0);
            e.de  = 4'(1 << ((k / 3) % 4));
            e.seg = 7'h00;
            exp_q.push_back(e);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (digit_enable0 !== e.de || segments0 !== e.seg || frame_start0 !== e.fs || bcd_ready0 !== 1'b1)
                $display("FAIL blank0_scan: got de=%b seg=%h fs=%b ready=%b required de=%b seg=%h fs=%b ready=1",
                         digit_enable0, segments0, frame_start0, bcd_ready0, e.de, e.seg, e.fs);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        reset0     = 1'b1;
        bcd        = '0;
        bcd_valid  = 1'b0;
        bcd0       = '0;
        bcd_valid0 = 1'b0;
        test_reset();
        test_idle();
        test_load();
        test_back_to_back();
        test_leading_zero();
        test_reset_mid_frame();
        test_blank_zero();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
